pattern_sequencer: RTL and testbench



---
 rtl/pattern_sequencer_pkg.sv | 49 ++++
 rtl/pattern_sequencer_if.sv | 28 ++
 rtl/pattern_sequencer_btn_debounce.sv | 50 +++++
 rtl/pattern_sequencer.sv | 116 +++++++++++
 tb/tb_pattern_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_sequencer_pkg.sv
// Shared encodings for the pattern sequencer: mode ids, field positions,
// scheduler states and the masked next/prev mode search.
package pattern_sequencer_pkg;

  typedef enum logic [2:0] {
    MODE_PASS = 3'd0,
    MODE_1    = 3'd1,
    MODE_2    = 3'd2,
    MODE_3    = 3'd3,
    MODE_4    = 3'd4,
    MODE_5    = 3'd5,
    MODE_6    = 3'd6,
    MODE_7    = 3'd7
  } mode_e;

  localparam int TIMING_BIT = 7;
  localparam int MODE_MSB   = 6;
  localparam int MODE_LSB   = 4;
  localparam int OPT_MSB    = 3;

  typedef enum logic {
    HOLD = 1'b0,
    PEND = 1'b1
  } state_e;

  // Returns {wrapped, mode}; mode is unchanged when no other bit is set.
  function automatic logic [3:0] step_mode(
    input logic [7:0] mask,
    input logic [2:0] cur,
    input logic       up
  );
    logic [2:0] cand;
    logic [2:0] res;
    logic       found;
    logic       wrap;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      cand = up ? cur + 3'(i) : cur - 3'(i);
      if (!found && mask[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    wrap = found && (up ? (res < cur) : (res > cur));
    return {wrap, res};
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Control/status bundle between the top-level inputs, the sequencer
// and the VGA pattern controller.
interface pattern_sequencer_if;
  logic        frame_tick;
  logic [7:0]  cfg_in;
  logic        auto_en;
  logic [1:0]  hold_sel;
  logic        btn_next;
  logic        btn_prev;
  logic [7:0]  mode_params;
  logic        mode_changed;
  logic [10:0] frames_in_mode;
  logic        pending;

  modport master (
    output frame_tick, cfg_in, auto_en,
    output hold_sel, btn_next, btn_prev,
    input  mode_params, mode_changed,
    input  frames_in_mode, pending
  );

  modport slave (
    input  frame_tick, cfg_in, auto_en,
    input  hold_sel, btn_next, btn_prev,
    output mode_params, mode_changed,
    output frames_in_mode, pending
  );
endinterface

// File: rtl/pattern_sequencer_btn_debounce.sv
// Raw button -> 2-FF sync -> stable-sample counter -> one-cycle press
// pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q + 16'd1 >= CYCLES) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous mode scheduler: queues one auto or manual step and
// applies it on frame_tick so a frame never shows two modes.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter logic [7:0]  MODE_MASK       = 8'b0111_0110,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [8:0]  HOLD_BASE       = 9'd60
) (
  input logic               clk,
  input logic               reset,
  pattern_sequencer_if.slave bus
);

  logic        next_evt, prev_evt;
  state_e      state_q, state_d;
  logic        up_q, up_d;
  logic        auto_q, auto_d;
  logic [7:0]  mp_q, mp_d;
  logic        chg_q, chg_d;
  logic [10:0] frames_q, frames_d;

  logic [10:0] hold_len;
  logic        hold_done;
  logic        one_evt;
  logic        cancel;
  logic        can_step;
  logic [2:0]  cur_mode;
  logic [3:0]  step_res;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn_next),
    .press_o (next_evt)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn_prev),
    .press_o (prev_evt)
  );

  assign hold_len  = {2'b00, HOLD_BASE} << bus.hold_sel;
  assign hold_done = ({1'b0, frames_q} + 12'd1)
                     >= {1'b0, hold_len};
  assign one_evt   = next_evt ^ prev_evt;
  assign can_step  = |MODE_MASK;
  assign cur_mode  = mp_q[MODE_MSB:MODE_LSB];
  assign step_res  = step_mode(MODE_MASK, cur_mode, up_q);
  assign cancel    = up_q ? (prev_evt & ~next_evt)
                          : (next_evt & ~prev_evt);

  always_comb begin
    state_d  = state_q;
    up_d     = up_q;
    auto_d   = auto_q;
    mp_d     = mp_q;
    chg_d    = 1'b0;
    frames_d = frames_q;
    unique case (state_q)
      HOLD: begin
        if (bus.frame_tick && frames_q != 11'h7FF)
          frames_d = frames_q + 11'd1;
        // Simultaneous presses also suppress an auto request.
        if (can_step && one_evt) begin
          state_d = PEND;
          up_d    = next_evt;
          auto_d  = 1'b0;
        end else if (can_step && !next_evt && bus.auto_en
                     && bus.frame_tick && hold_done) begin
          state_d = PEND;
          up_d    = 1'b1;
          auto_d  = 1'b1;
        end
      end
      PEND: begin
        if (cancel) begin
          state_d = HOLD;
        end else if (bus.frame_tick) begin
          state_d  = HOLD;
          frames_d = '0;
          mp_d[MODE_MSB:MODE_LSB] = step_res[2:0];
          chg_d = step_res[2:0] != cur_mode;
          if (auto_q && step_res[3])
            mp_d[1:0] = mp_q[1:0] + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HOLD;
      up_q     <= 1'b1;
      auto_q   <= 1'b0;
      mp_q     <= bus.cfg_in;
      chg_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      up_q     <= up_d;
      auto_q   <= auto_d;
      mp_q     <= mp_d;
      chg_q    <= chg_d;
      frames_q <= frames_d;
    end
  end

  assign bus.mode_params    = mp_q;
  assign bus.mode_changed   = chg_q;
  assign bus.frames_in_mode = frames_q;
  assign bus.pending        = (state_q == PEND);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus random stimulus,
// all checked every cycle against a behavioural model.
module tb_pattern_sequencer;

  localparam logic [7:0] MASK = 8'b0111_0110;
  localparam int NDB = 4;
  localparam int HB  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_sequencer_if bus();

  pattern_sequencer #(
    .MODE_MASK       (MASK),
    .DEBOUNCE_CYCLES (16'(NDB)),
    .HOLD_BASE       (9'(HB))
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  logic [7:0] mask_v = MASK;
  logic [7:0] m_params;
  bit         m_chg, m_pend, m_auto;
  int         m_frames, m_dir;
  bit         s1[2], s2[2], lvl[2], prs[2];
  int         run_c[2];

  task automatic model_edge();
    bit evn, evp, opp, found, wrap;
    bit raw[2];
    int hold, cur, nm, c;
    raw[0] = bus.btn_next;
    raw[1] = bus.btn_prev;
    if (reset) begin
      m_params = bus.cfg_in;
      m_chg = 0; m_pend = 0; m_auto = 0;
      m_frames = 0; m_dir = 1;
      for (int b = 0; b < 2; b++) begin
        s1[b] = 0; s2[b] = 0; lvl[b] = 0;
        prs[b] = 0; run_c[b] = 0;
      end
      return;
    end
    evn = prs[0];
    evp = prs[1];
    m_chg = 0;
    if (!m_pend) begin
      hold = HB << bus.hold_sel;
      if (mask_v != 0 && evn != evp) begin
        m_pend = 1; m_dir = evn ? 1 : -1; m_auto = 0;
      end else if (mask_v != 0 && !evn && bus.auto_en
                   && bus.frame_tick && m_frames + 1 >= hold) begin
        m_pend = 1; m_dir = 1; m_auto = 1;
      end
      if (bus.frame_tick && m_frames < 2047) m_frames++;
    end else begin
      opp = (m_dir > 0) ? (evp && !evn) : (evn && !evp);
      if (opp) m_pend = 0;
      else if (bus.frame_tick) begin
        cur = int'(m_params[6:4]);
        nm = cur; found = 0; wrap = 0;
        for (int k = 1; k < 8; k++) begin
          c = (cur + m_dir * k + 8) % 8;
          if (!found && mask_v[c]) begin
            found = 1; nm = c;
            wrap = (cur + m_dir * k >= 8) || (cur + m_dir * k < 0);
          end
        end
        m_chg = (nm != cur);
        m_params[6:4] = 3'(nm);
        if (m_auto && wrap) m_params[1:0] = m_params[1:0] + 2'd1;
        m_frames = 0;
        m_pend = 0;
      end
    end
    for (int b = 0; b < 2; b++) begin
      prs[b] = 0;
      if (s2[b] == lvl[b]) run_c[b] = 0;
      else begin
        run_c[b]++;
        if (run_c[b] >= NDB) begin
          lvl[b] = s2[b]; run_c[b] = 0; prs[b] = lvl[b];
        end
      end
      s2[b] = s1[b];
      s1[b] = raw[b];
    end
  endtask

  always @(posedge clk) begin
    model_edge();
    #1;
    vectors++;
    if (bus.mode_params !== m_params || bus.mode_changed !== m_chg
        || int'(bus.frames_in_mode) != m_frames
        || bus.pending !== m_pend) begin
      miscompares++;
      $display("FAIL cycle_cmp t=%0t got params=%h chg=%b frames=%0d pend=%b expected params=%h chg=%b frames=%0d pend=%b",
               $time, bus.mode_params, bus.mode_changed,
               bus.frames_in_mode, bus.pending,
               m_params, m_chg, m_frames, m_pend);
    end
  end

  // ---------------- stimulus helpers ----------------
  int fl = 32;
  int fcnt = 0;
  int ticks = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ticks += int'(bus.frame_tick);
    bus.frame_tick = (fcnt >= fl - 1);
    fcnt = (fcnt >= fl - 1) ? 0 : fcnt + 1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input logic [7:0] cfg);
    bus.cfg_in = cfg;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    bus.frame_tick = 1'b0;
    fcnt = 0;
    ticks = 0;
  endtask

  task automatic wait_change(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (bus.mode_changed) begin
        got = 1;
        break;
      end
    end
    chk({name, "_timeout"}, int'(got), 1);
  endtask

  task automatic align();
    int t0;
    t0 = ticks;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ticks != t0) break;
    end
  endtask

  task automatic press_next(input int n);
    bus.btn_next = 1'b1; run(n); bus.btn_next = 1'b0;
  endtask

  task automatic press_prev(input int n);
    bus.btn_prev = 1'b1; run(n); bus.btn_prev = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] auto_exp [5] = '{8'h20, 8'h40, 8'h50, 8'h60, 8'h11};

  initial begin
    reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.cfg_in = 8'h10;
    bus.auto_en = 1'b0;
    bus.hold_sel = 2'd0;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    do_reset(8'h10);
    chk("load_params", int'(bus.mode_params), 'h10);
    chk("load_pending", int'(bus.pending), 0);
    chk("load_frames", int'(bus.frames_in_mode), 0);

    bus.auto_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ticks = 0;
      wait_change("auto");
      chk("auto_params", int'(bus.mode_params), int'(auto_exp[i]));
      chk("auto_ticks", ticks, 4);
      run(1);
      chk("auto_pulse", int'(bus.mode_changed), 0);
    end
    bus.auto_en = 1'b0;

    press_next(10);
    wait_change("next1");
    chk("next1_params", int'(bus.mode_params), 'h21);
    run(3);
    press_next(10);
    chk("next2_pending", int'(bus.pending), 1);
    chk("next2_hold", int'(bus.mode_params), 'h21);
    wait_change("next2");
    chk("next2_params", int'(bus.mode_params), 'h41);
    chk("next2_frames", int'(bus.frames_in_mode), 0);
    chk("next2_pend_clr", int'(bus.pending), 0);

    press_prev(10);
    wait_change("prev1");
    press_prev(10);
    wait_change("prev2");
    chk("prev2_params", int'(bus.mode_params), 'h11);
    bus.btn_prev = 1'b1; run(1);
    bus.btn_prev = 1'b0; run(1);
    press_prev(12);
    wait_change("bounce");
    chk("bounce_params", int'(bus.mode_params), 'h61);
    run(2 * fl);
    chk("bounce_single", int'(bus.mode_params), 'h61);

    align();
    press_next(8);
    run(2);
    chk("cancel_pend", int'(bus.pending), 1);
    press_prev(8);
    run(2);
    chk("cancel_drop", int'(bus.pending), 0);
    align();
    chk("cancel_params", int'(bus.mode_params), 'h61);

    align();
    bus.btn_next = 1'b1;
    bus.btn_prev = 1'b1;
    run(8);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    run(2);
    chk("simul_pend", int'(bus.pending), 0);
    align();
    chk("simul_params", int'(bus.mode_params), 'h61);

    align();
    press_next(8);
    run(2);
    chk("rstp_pend", int'(bus.pending), 1);
    do_reset(8'hA3);
    chk("rstp_params", int'(bus.mode_params), 'hA3);
    chk("rstp_pend_clr", int'(bus.pending), 0);
    align();
    align();
    chk("rstp_nochange", int'(bus.mode_params), 'hA3);

    fl = 2;
    run(4200);
    chk("frames_sat", int'(bus.frames_in_mode), 2047);
    fl = 32;

    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 59) == 0)
        do_reset(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0)
        bus.auto_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0)
        bus.hold_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        fl = $urandom_range(3, 40);
      bus.btn_next = ($urandom_range(0, 3) == 0);
      bus.btn_prev = ($urandom_range(0, 3) == 0);
      run($urandom_range(1, 14));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
